// File: rtl/add_subt_arbiter_pkg.sv
// add_subt_arb_pkg: FSM state encoding, default timeout and clog2 helper for add_subt_arbiter
package add_subt_arb_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int DEFAULT_TIMEOUT = 255;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/add_subt_arbiter_rr_priority_select.sv
// rr_priority_select: picks the first set req bit after last_grant with wrap-around (req, last_grant -> grant, any_req)
module rr_priority_select #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any_req
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  assign dbl     = {req, req};
  assign rot     = N'(dbl >> (int'(last_grant) + 1));
  assign any_req = |req;
  always_comb begin
    grant = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) grant = IW'((int'(last_grant) + 1 + j) % N);
  end
endmodule

// File: rtl/add_subt_arbiter.sv
// add_subt_arbiter: round-robin sharing of one FP add/sub unit (REQ/OP_A/OP_B/SUB -> ACK/ERR/RESULT/BUSY; SUM_A/SUM_B/ADD_SUBT/RST_SUM/Begin_SUM <-> ACK_ADD_SUBT/SUM_RESULT) with timeout abort
module add_subt_arbiter
  import add_subt_arb_pkg::*;
#(
  parameter int W       = 32,
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] OP_A,
  input  logic [N_REQ*W-1:0] OP_B,
  input  logic [N_REQ-1:0]   SUB,
  output logic [N_REQ-1:0]   ACK,
  output logic [N_REQ-1:0]   ERR,
  output logic [W-1:0]       RESULT,
  output logic               BUSY,
  output logic [W-1:0]       SUM_A,
  output logic [W-1:0]       SUM_B,
  output logic               ADD_SUBT,
  output logic               RST_SUM,
  output logic               Begin_SUM,
  input  logic               ACK_ADD_SUBT,
  input  logic [W-1:0]       SUM_RESULT
);
  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(TIMEOUT + 1);
  state_t          state, nxt;
  logic [IW-1:0]   g, last_grant, pick;
  logic            any_req, err_flag, timed_out;
  logic [CW-1:0]   cnt, cnt_inc;
  logic [N_REQ-1:0] g_hot;
  logic [W-1:0]    op_a_arr [N_REQ];
  logic [W-1:0]    op_b_arr [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a_arr[i] = OP_A[i*W +: W];
    assign op_b_arr[i] = OP_B[i*W +: W];
  end
  rr_priority_select #(.N(N_REQ), .IW(IW)) u_sel (
    .req       (REQ),
    .last_grant(last_grant),
    .grant     (pick),
    .any_req   (any_req)
  );
  assign cnt_inc   = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign timed_out = cnt_inc == CW'(TIMEOUT);
  assign g_hot     = N_REQ'(1) << g;
  assign ACK       = (state == DONE) ? g_hot : '0;
  assign ERR       = (state == DONE && err_flag) ? g_hot : '0;
  assign BUSY      = state != IDLE;
  assign RST_SUM   = state == LOAD;
  assign Begin_SUM = state == START;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any_req ? LOAD : IDLE;
      LOAD:    nxt = START;
      START:   nxt = WAIT;
      WAIT:    nxt = (ACK_ADD_SUBT || timed_out) ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      g          <= '0;
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
      err_flag   <= 1'b0;
      RESULT     <= '0;
      SUM_A      <= '0;
      SUM_B      <= '0;
      ADD_SUBT   <= 1'b0;
    end else begin
      if (state == IDLE && any_req) g <= pick;
      if (state == LOAD) begin
        SUM_A    <= op_a_arr[g];
        SUM_B    <= op_b_arr[g];
        ADD_SUBT <= SUB[g];
      end
      if (state == START) begin
        cnt      <= '0;
        err_flag <= 1'b0;
      end
      if (state == WAIT) begin
        cnt <= cnt_inc;
        if (ACK_ADD_SUBT) RESULT <= SUM_RESULT;
        else if (timed_out) err_flag <= 1'b1;
      end
      if (state == DONE) last_grant <= g;
    end
  end
endmodule

// File: tb/tb_add_subt_arbiter.sv
// tb_add_subt_arbiter: directed scoreboard bench for add_subt_arbiter
module tb_add_subt_arbiter;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int TO = 8;
  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [W-1:0] res;
  } exp_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] SUB = '0;
  logic [N*W-1:0] OP_A, OP_B;
  logic [N-1:0] ACK, ERR;
  logic [W-1:0] RESULT, SUM_A, SUM_B;
  logic [W-1:0] SUM_RESULT = '0;
  logic BUSY, ADD_SUBT, RST_SUM, Begin_SUM, ACK_ADD_SUBT;
  logic unit_ack = 1'b0;
  logic force_ack = 1'b0;
  int unit_lat = 0;
  bit use_fixed = 1'b0;
  logic [W-1:0] fixed_res = '0;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [W-1:0] rr_res [N];
  int checks = 0;
  int errors = 0;
  int acks_seen = 0;
  logic [N-1:0] last_ack = '0;
  exp_t sb[$];

  always #5 CLK = ~CLK;
  assign ACK_ADD_SUBT = unit_ack | force_ack;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign OP_A[i*W +: W] = a[i];
    assign OP_B[i*W +: W] = b[i];
  end

  add_subt_arbiter #(.W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP_A(OP_A), .OP_B(OP_B), .SUB(SUB),
    .ACK(ACK), .ERR(ERR), .RESULT(RESULT), .BUSY(BUSY), .SUM_A(SUM_A), .SUM_B(SUM_B),
    .ADD_SUBT(ADD_SUBT), .RST_SUM(RST_SUM), .Begin_SUM(Begin_SUM),
    .ACK_ADD_SUBT(ACK_ADD_SUBT), .SUM_RESULT(SUM_RESULT)
  );

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_op(input int i, input bit e, input logic [W-1:0] r);
    exp_t x;
    x.ack = N'(1) << i;
    x.err = e ? x.ack : '0;
    x.res = r;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input int budget);
    int start;
    int c;
    start = acks_seen;
    c = 0;
    while (acks_seen == start && c < budget) begin
      tick();
      c++;
    end
    if (acks_seen == start) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: got no ACK within %0d cycles, want one", budget);
    end
    REQ = REQ & ~last_ack;
  endtask

  initial forever begin
    @(negedge CLK);
    if (Begin_SUM && unit_lat > 0) begin
      repeat (unit_lat) @(posedge CLK);
      #1;
      unit_ack = 1'b1;
      SUM_RESULT = use_fixed ? fixed_res : (ADD_SUBT ? SUM_A - SUM_B : SUM_A + SUM_B);
      @(posedge CLK);
      #1;
      unit_ack = 1'b0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && (ACK != '0 || ERR != '0)) begin
        acks_seen++;
        last_ack = ACK;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ACK=%b ERR=%b, want no ACK", ACK, ERR);
        end else begin
          e = sb.pop_front();
          chk("sb_ack", 32'(ACK), 32'(e.ack));
          chk("sb_err", 32'(ERR), 32'(e.err));
          chk("sb_result", RESULT, e.res);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test by 50000 ns, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    #2;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_result", RESULT, 0);
    chk("rst_sum_a", SUM_A, 0);
    chk("rst_begin", 32'(Begin_SUM), 0);
    chk("rst_rst_sum", 32'(RST_SUM), 0);
    tick(2);
    RST_N = 1'b1;
    a[0] = 32'h3F80_0000;
    b[0] = 32'h4000_0000;
    use_fixed = 1'b1;
    fixed_res = 32'h4040_0000;
    unit_lat = 3;
    tick();
    REQ = 3'b001;
    expect_op(0, 1'b0, 32'h4040_0000);
    tick();
    chk("single_rst_sum", 32'(RST_SUM), 1);
    chk("single_busy", 32'(BUSY), 1);
    tick();
    chk("single_begin", 32'(Begin_SUM), 1);
    chk("single_sum_a", SUM_A, 32'h3F80_0000);
    chk("single_sum_b", SUM_B, 32'h4000_0000);
    chk("single_add_subt", 32'(ADD_SUBT), 0);
    tick(3);
    chk("single_no_early_ack", 32'(ACK), 0);
    tick();
    chk("single_ack", 32'(ACK), 1);
    chk("single_result", RESULT, 32'h4040_0000);
    tick();
    REQ = '0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    a[0] = 32'h0000_1111; b[0] = 32'h0000_0001; rr_res[0] = 32'h0000_1112;
    a[1] = 32'h0000_2222; b[1] = 32'h0000_0002; rr_res[1] = 32'h0000_2220;
    a[2] = 32'h0000_3333; b[2] = 32'h0000_0003; rr_res[2] = 32'h0000_3336;
    SUB = 3'b010;
    use_fixed = 1'b0;
    unit_lat = 1;
    for (int k = 0; k < 32; k++) expect_op(k % 3, 1'b0, rr_res[k % 3]);
    REQ = 3'b111;
    for (int k = 0; k < 30; k++) begin
      wait_ack(20);
      tick();
      if (k < 29) REQ = REQ | last_ack;
    end
    wait_ack(20);
    wait_ack(20);
    chk("rr_req_drained", 32'(REQ), 0);
    tick();
    unit_lat = 0;
    REQ = 3'b001;
    expect_op(0, 1'b1, 32'h0000_2220);
    tick(10);
    chk("timeout_no_early_ack", 32'(ACK), 0);
    tick();
    chk("timeout_ack", 32'(ACK), 1);
    chk("timeout_err", 32'(ERR), 1);
    chk("timeout_result_held", RESULT, 32'h0000_2220);
    tick();
    a[1] = 32'h0000_5555;
    unit_lat = 1;
    REQ = 3'b010;
    expect_op(1, 1'b0, 32'h0000_5553);
    wait_ack(20);
    a[0] = 32'h3F80_0000;
    b[0] = 32'h3F80_0000;
    SUB = 3'b000;
    use_fixed = 1'b1;
    fixed_res = 32'hC0A0_0000;
    unit_lat = 8;
    REQ = 3'b001;
    expect_op(0, 1'b0, 32'hC0A0_0000);
    tick(11);
    chk("collide_ack", 32'(ACK), 1);
    chk("collide_err", 32'(ERR), 0);
    chk("collide_result", RESULT, 32'hC0A0_0000);
    tick();
    unit_lat = 0;
    REQ = 3'b001;
    tick(5);
    chk("midwait_busy", 32'(BUSY), 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_ack", 32'(ACK), 0);
    chk("midrst_sum_a", SUM_A, 0);
    chk("midrst_result", RESULT, 0);
    REQ = 3'b100;
    a[2] = 32'h0000_7000;
    b[2] = 32'h0000_0010;
    use_fixed = 1'b0;
    unit_lat = 1;
    expect_op(2, 1'b0, 32'h0000_7010);
    tick(2);
    RST_N = 1'b1;
    tick();
    chk("postrst_load", 32'(RST_SUM), 1);
    tick();
    chk("postrst_sum_a", SUM_A, 32'h0000_7000);
    wait_ack(20);
    unit_lat = 2;
    force_ack = 1'b1;
    REQ = 3'b001;
    expect_op(0, 1'b0, 32'h7F00_0000);
    tick(2);
    a[0] = 32'hDEAD_BEEF;
    tick();
    force_ack = 1'b0;
    chk("stale_sum_a", SUM_A, 32'h3F80_0000);
    chk("stale_no_ack_c3", 32'(ACK), 0);
    tick();
    chk("stale_no_ack_c4", 32'(ACK), 0);
    tick();
    chk("stale_ack", 32'(ACK), 1);
    chk("stale_result", RESULT, 32'h7F00_0000);
    tick();
    REQ = '0;
    tick(3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_subt_arbiter.md
Name: add_subt_arbiter

Overview:
- Shares one floating-point add/subtract unit between N_REQ requesters, e.g. the X, Y and Z update paths of the CORDIC logarithm datapath.
- Round-robin arbitration; latches the winner's operands; drives the unit's Begin_SUM / ACK_ADD_SUBT handshake.
- Returns the result to the winner with a one-cycle ACK pulse.
- A watchdog aborts operations the unit never acknowledges.

Parameters:
W, 32, operand/result width (single precision)
N_REQ, 3, number of requesters (2..8)
TIMEOUT, 255, maximum cycles spent in WAIT before abort (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ  in  N_REQ  level request per requester; held until its ACK
OP_A  in  N_REQ*W  operand A per requester; slice i = bits [i*W+W-1 : i*W]
OP_B  in  N_REQ*W  operand B per requester, same packing
SUB  in  N_REQ  1 = subtract (A-B), 0 = add
ACK  out  N_REQ  one-cycle done pulse to the granted requester
ERR  out  N_REQ  one-cycle timeout pulse; coincides with ACK
RESULT  out  W  last captured sum; valid while ACK is high; held afterwards
BUSY  out  1  high in every state except IDLE
SUM_A  out  W  operand A to the shared unit
SUM_B  out  W  operand B to the shared unit
ADD_SUBT  out  1  operation select to the shared unit
RST_SUM  out  1  one-cycle clear pulse to the shared unit
Begin_SUM  out  1  one-cycle start pulse to the shared unit
ACK_ADD_SUBT  in  1  unit done (level or pulse)
SUM_RESULT  in  W  unit result, valid while ACK_ADD_SUBT is high

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE; all outputs 0; RESULT=0.
  - Wait counter=0; last_grant=N_REQ-1, so requester 0 has first priority.
- All outputs are registered or decoded from state only (Moore); no combinational path from inputs to outputs.
- IDLE:
  - If any REQ bit is high, select the first requester set in REQ, scanning from last_grant+1 with wrap-around.
  - Latch the grant index g; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - SUM_A<=OP_A[g], SUM_B<=OP_B[g], ADD_SUBT<=SUB[g]; RST_SUM=1.
  - Operands are sampled here only; later changes on OP_A/OP_B/SUB are ignored.
- START (1 cycle): Begin_SUM=1; clear the wait counter.
- WAIT:
  - Counter increments each cycle.
  - ACK_ADD_SUBT=1: RESULT<=SUM_RESULT; go to DONE.
  - Else, if the counter reaches TIMEOUT: go to DONE with an error flag; RESULT unchanged.
  - If ACK_ADD_SUBT=1 in the same cycle the timeout fires, the ack wins and no error is raised.
- DONE (1 cycle):
  - ACK[g]=1; ERR[g]=error flag.
  - last_grant<=g; go to IDLE.
- Latency: REQ high in IDLE at cycle 0 -> LOAD at cycle 1 -> START at cycle 2 -> WAIT from cycle 3. ACK_ADD_SUBT sampled in WAIT at cycle j gives ACK at cycle j+1. Minimum latency is 4 cycles.
- ACK_ADD_SUBT outside WAIT is ignored, including a stale level held over from the previous operation.
- REQ dropped mid-operation: the operation still completes and ACK[g] still pulses.
- A requester must deassert REQ in the cycle after its ACK. REQ still high in IDLE is treated as a new request, subject to round-robin order.
- Back-to-back: the next grant can enter LOAD 2 cycles after the previous DONE (DONE -> IDLE -> LOAD).
- Reset asserted mid-operation returns to IDLE immediately. No ACK or ERR is issued for the aborted operation.
- Widths:
  - Wait counter is clog2(TIMEOUT+1) bits and saturates; no wrap.
  - Grant index is clog2(N_REQ) bits.

Decomposition:
- Package add_subt_arb_pkg: state encoding localparams (IDLE, LOAD, START, WAIT, DONE; 3-bit), default TIMEOUT, and a clog2 function.
- One sub-module, rr_priority_select: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_req.
  - Reusable by other shared-resource arbiters in the FPU.

Test Plan:
- Single request: REQ=001, OP_A=0x3F800000, OP_B=0x40000000, SUB=0; unit acks 3 cycles after Begin_SUM with 0x40400000 -> SUM_A/SUM_B/ADD_SUBT match; RST_SUM at cycle 1, Begin_SUM at cycle 2; ACK=001 with RESULT=0x40400000 at cycle 6.
- Round-robin: REQ=111 held, each requester dropping REQ after its ACK, unit acks in 1 cycle -> grant order 0,1,2; then REQ=011 -> grant order 0,1; no starvation over 30 operations.
- Timeout: TIMEOUT=8, ACK_ADD_SUBT never asserted -> ACK[g]=1 and ERR[g]=1 together, 8 cycles after entering WAIT; RESULT unchanged; next request proceeds normally.
- Ack/timeout collision: ACK_ADD_SUBT first asserted in the cycle the counter reaches TIMEOUT -> ERR=0; RESULT=SUM_RESULT.
- Reset mid-WAIT: RST_N=0 for 2 cycles during WAIT -> all outputs 0 immediately; no ACK issued; after release, pending REQ=100 is granted with requester 2 entering LOAD one cycle after the first IDLE cycle.
- Stale ack and operand change: ACK_ADD_SUBT held high from a previous operation and OP_A changed after LOAD -> the stale ack is ignored before WAIT; SUM_A keeps the LOAD-time value.
